// File: rtl/mem_stage.sv
// Memory stage: holds one instruction from execute, waits for load data and aligns it for writeback.
// Optional MEM_UNALIGNED_LOAD_EN enables lwl/lwr merging with rt_value; otherwise they act as lw.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [104:0] es_to_ms_bus,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [69:0]  ms_to_ws_bus,
    output logic [38:0]  ms_to_ds_fwd_bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HAVE = 2'd2;

    localparam logic [2:0] LT_NONE = 3'd0;
    localparam logic [2:0] LT_LB   = 3'd1;
    localparam logic [2:0] LT_LBU  = 3'd2;
    localparam logic [2:0] LT_LH   = 3'd3;
    localparam logic [2:0] LT_LHU  = 3'd4;
`ifdef MEM_UNALIGNED_LOAD_EN
    localparam logic [2:0] LT_LWL  = 3'd6;
    localparam logic [2:0] LT_LWR  = 3'd7;
`endif

    // Handshake: a transfer happens on a rising edge where valid && allowin (upstream)
    // or ms_to_ws_valid && ws_allowin (downstream); ms_allowin never depends on es_to_ms_valid.
    logic         ms_valid_q, ms_valid_d;
    logic [104:0] ms_bus_q, ms_bus_d;
    logic [1:0]   state_q, state_d;
    logic [31:0]  buf_q, buf_d;

    logic [2:0]  load_type;
    logic [31:0] rt_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [1:0]  offset;
    logic        is_load;
    logic        in_is_load;
    logic        cur_wait;
    logic        ms_ready_go;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] final_result;
    logic        fwd_we;
    logic        fwd_pending;

    assign {load_type, rt_value, gr_we, dest, alu_result, pc} = ms_bus_q;
    assign offset     = alu_result[1:0];
    assign is_load    = (load_type != LT_NONE);
    assign in_is_load = (es_to_ms_bus[104:102] != LT_NONE);
    assign cur_wait   = ms_valid_q && (state_q == WAIT);

    assign ms_ready_go    = !is_load || (state_q == HAVE) ||
                            ((state_q == WAIT) && data_sram_data_ok);
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    // A data_ok seen while the resident load waits belongs to it, even if a new load enters.
    always_comb begin
        ms_valid_d = ms_valid_q;
        ms_bus_d   = ms_bus_q;
        state_d    = state_q;
        buf_d      = buf_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
            state_d    = IDLE;
            if (es_to_ms_valid) begin
                ms_bus_d = es_to_ms_bus;
                if (in_is_load) begin
                    if (data_sram_data_ok && !cur_wait) begin
                        state_d = HAVE;
                        buf_d   = data_sram_rdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
        end else if (cur_wait && data_sram_data_ok) begin
            state_d = HAVE;
            buf_d   = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            ms_bus_q   <= '0;
            state_q    <= IDLE;
            buf_q      <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            ms_bus_q   <= ms_bus_d;
            state_q    <= state_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        ld_word = (state_q == HAVE) ? buf_q : data_sram_rdata;
        case (offset)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = offset[1] ? ld_word[31:16] : ld_word[15:0];
    end

`ifdef MEM_UNALIGNED_LOAD_EN
    logic [31:0] lwl_word;
    logic [31:0] lwr_word;

    // Little-endian merge: lwl fills from the top, lwr fills from the bottom.
    always_comb begin
        case (offset)
            2'd0:    lwl_word = {ld_word[7:0],  rt_value[23:0]};
            2'd1:    lwl_word = {ld_word[15:0], rt_value[15:0]};
            2'd2:    lwl_word = {ld_word[23:0], rt_value[7:0]};
            default: lwl_word = ld_word;
        endcase
        case (offset)
            2'd0:    lwr_word = ld_word;
            2'd1:    lwr_word = {rt_value[31:24], ld_word[31:8]};
            2'd2:    lwr_word = {rt_value[31:16], ld_word[31:16]};
            default: lwr_word = {rt_value[31:8],  ld_word[31:24]};
        endcase
    end
`else
    logic unused_rt_value;
    assign unused_rt_value = ^rt_value;
`endif

    always_comb begin
        case (load_type)
            LT_NONE: final_result = alu_result;
            LT_LB:   final_result = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  final_result = {24'd0, ld_byte};
            LT_LH:   final_result = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  final_result = {16'd0, ld_half};
`ifdef MEM_UNALIGNED_LOAD_EN
            LT_LWL:  final_result = lwl_word;
            LT_LWR:  final_result = lwr_word;
`endif
            default: final_result = ld_word;
        endcase
    end

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    assign fwd_we      = ms_valid_q && gr_we;
    assign fwd_pending = fwd_we && is_load && !ms_ready_go;
    assign ms_to_ds_fwd_bus = fwd_we ? {1'b1, fwd_pending, dest, final_result} : 39'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized instruction stream checked
// against a transaction-level model with an expected-output queue.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [104:0] es_to_ms_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic [38:0]  ms_to_ds_fwd_bus;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_fwd_bus  (ms_to_ds_fwd_bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and model of the single resident instruction
    logic [69:0] exp_q[$];
    logic        cur_is_load;
    logic        cur_have;
    logic        pend;
    int          left;
    logic [31:0] pend_rd;

    logic        smp_valid;
    logic        smp_allowin;
    logic [69:0] smp_bus;
    logic [38:0] smp_fwd;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [104:0] mk_bus(input logic [2:0] lt, input logic [31:0] rt,
                                            input logic we, input logic [4:0] dst,
                                            input logic [31:0] alu, input logic [31:0] pcv);
        return {lt, rt, we, dst, alu, pcv};
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] lt, input logic [31:0] alu,
                                               input logic [31:0] rt, input logic [31:0] rd);
        logic [7:0] m [4];
        logic [7:0] r [4];
        logic [7:0] o [4];
        int k, kh, v;
        for (int i = 0; i < 4; i++) begin
            m[i] = rd[8*i +: 8];
            r[i] = rt[8*i +: 8];
            o[i] = 8'd0;
        end
        k  = int'(alu[1:0]);
        kh = (k >= 2) ? 2 : 0;
        case (lt)
            3'd0: return alu;
            3'd1: begin v = int'(m[k]); if (v >= 128) v -= 256; return 32'(v); end
            3'd2: return 32'(int'(m[k]));
            3'd3: begin
                v = int'(m[kh]) + 256 * int'(m[kh+1]);
                if (v >= 32768) v -= 65536;
                return 32'(v);
            end
            3'd4: return 32'(int'(m[kh]) + 256 * int'(m[kh+1]));
`ifdef MEM_UNALIGNED_LOAD_EN
            3'd6: begin
                for (int i = 0; i < 4; i++) o[i] = (i >= 3 - k) ? m[i - (3 - k)] : r[i];
                return {o[3], o[2], o[1], o[0]};
            end
            3'd7: begin
                for (int i = 0; i < 4; i++) o[i] = (i <= 3 - k) ? m[i + k] : r[i];
                return {o[3], o[2], o[1], o[0]};
            end
`endif
            default: return rd;
        endcase
    endfunction

    task automatic model_clear();
        exp_q.delete();
        cur_is_load = 1'b0;
        cur_have    = 1'b0;
        pend        = 1'b0;
        left        = 0;
        pend_rd     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom();
        ws_allowin        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", ms_to_ws_valid, 0);
        check("rst_allowin", ms_allowin, 1);
        check("rst_fwd", ms_to_ds_fwd_bus, 0);
        reset = 1'b0;
        model_clear();
    endtask

    // One clock cycle: drive inputs, let the memory responder answer, check outputs, update model.
    // d = cycles after the capture cycle at which data_ok returns (0 = same cycle).
    task automatic run_cycle(input logic offer, input logic [104:0] bus, input int d,
                             input logic [31:0] rd, input logic ws, output logic taken);
        logic fire, occ, ready, m_allowin, is_ld, dok, exp_we, exp_pend;
        int dd;
        @(negedge clk);
        es_to_ms_valid = offer;
        es_to_ms_bus   = bus;
        ws_allowin     = ws;
        fire = 1'b0;
        if (pend) begin
            left--;
            if (left == 0) fire = 1'b1;
        end
        occ       = (exp_q.size() != 0);
        ready     = occ && (!cur_is_load || cur_have || fire);
        m_allowin = !occ || (ready && ws);
        taken     = offer && m_allowin;
        is_ld     = (bus[104:102] != 3'd0);
        dd        = (is_ld && fire && d == 0) ? 1 : d;
        dok       = fire || (taken && is_ld && dd == 0);
        data_sram_data_ok = dok;
        data_sram_rdata   = fire ? pend_rd : (dok ? rd : $urandom());
        #2;
        smp_valid   = ms_to_ws_valid;
        smp_allowin = ms_allowin;
        smp_bus     = ms_to_ws_bus;
        smp_fwd     = ms_to_ds_fwd_bus;
        check("valid", smp_valid, ready);
        check("allowin", smp_allowin, m_allowin);
        exp_we   = occ && exp_q[0][69];
        exp_pend = exp_we && cur_is_load && !ready;
        if (exp_we) begin
            check("fwd_hdr", smp_fwd[38:32], {1'b1, exp_pend, exp_q[0][68:64]});
            if (!exp_pend) check("fwd_result", smp_fwd[31:0], exp_q[0][63:32]);
        end else begin
            check("fwd_zero", smp_fwd, 0);
        end
        if (ready) check("ws_bus", smp_bus, exp_q[0]);
        if (fire) begin
            pend     = 1'b0;
            cur_have = 1'b1;
        end
        if (ready && ws) void'(exp_q.pop_front());
        if (taken) begin
            exp_q.push_back({bus[69], bus[68:64],
                             ref_result(bus[104:102], bus[63:32], bus[101:70], rd), bus[31:0]});
            cur_is_load = is_ld;
            cur_have    = is_ld && dd == 0;
            if (is_ld && dd != 0) begin
                pend    = 1'b1;
                left    = dd;
                pend_rd = rd;
            end
        end
    endtask

    task automatic idle_cycle(input logic ws);
        logic tk;
        run_cycle(1'b0, '0, 0, 32'd0, ws, tk);
    endtask

    initial begin
        logic        tk;
        logic [2:0]  lt;
        logic [31:0] alu, rt, rd;
        logic [104:0] bus;
        int          d;
        logic [31:0] exp_lwl;

        reset = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        ws_allowin = 1'b1;
        model_clear();
        do_reset();

        // Non-load passes through with one cycle of latency
        run_cycle(1'b1, mk_bus(3'd0, 32'hDEAD_0000, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000),
                  0, 32'd0, 1'b1, tk);
        check("r28_taken", tk, 1);
        idle_cycle(1'b1);
        check("r28_valid", smp_valid, 1);
        check("r28_result", smp_bus[63:32], 32'h1234_5678);
        check("r28_fwd", smp_fwd[38:32], {1'b1, 1'b0, 5'd5});

        // lb offset 3, two pending cycles before data
        run_cycle(1'b1, mk_bus(3'd1, 32'd0, 1'b1, 5'd9, 32'h0000_0103, 32'h0000_1004),
                  3, 32'h80FF_0000, 1'b1, tk);
        idle_cycle(1'b1);
        check("r29_pend1", smp_fwd[37], 1);
        idle_cycle(1'b1);
        check("r29_pend2", smp_fwd[37], 1);
        idle_cycle(1'b1);
        check("r29_valid", smp_valid, 1);
        check("r29_result", smp_bus[63:32], 32'hFFFF_FF80);
        check("r29_nopend", smp_fwd[37], 0);

        // lhu offset 2, writeback stalls for three cycles
        run_cycle(1'b1, mk_bus(3'd4, 32'd0, 1'b1, 5'd3, 32'h0000_2002, 32'h0000_1008),
                  1, 32'hBEEF_0000, 1'b1, tk);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, mk_bus(3'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0777, 32'h0000_100C),
                      0, 32'd0, 1'b0, tk);
            check("r30_result", smp_bus[63:32], 32'h0000_BEEF);
            check("r30_allowin", smp_allowin, 0);
        end
        run_cycle(1'b1, mk_bus(3'd0, 32'd0, 1'b1, 5'd1, 32'h0000_0777, 32'h0000_100C),
                  0, 32'd0, 1'b1, tk);
        check("r30_accept", tk, 1);
        idle_cycle(1'b1);

        // lwl offset 1, data returned in the capture cycle
`ifdef MEM_UNALIGNED_LOAD_EN
        exp_lwl = 32'hCCDD_3344;
`else
        exp_lwl = 32'hAABB_CCDD;
`endif
        run_cycle(1'b1, mk_bus(3'd6, 32'h1122_3344, 1'b1, 5'd7, 32'h0000_3001, 32'h0000_1010),
                  0, 32'hAABB_CCDD, 1'b1, tk);
        idle_cycle(1'b1);
        check("r31_result", smp_bus[63:32], exp_lwl);
        idle_cycle(1'b1);

        // Reset while a load waits; the late data_ok must be ignored
        run_cycle(1'b1, mk_bus(3'd5, 32'd0, 1'b1, 5'd8, 32'h0000_4000, 32'h0000_1014),
                  20, 32'h5555_AAAA, 1'b1, tk);
        idle_cycle(1'b1);
        do_reset();
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        #2;
        check("r32_valid", ms_to_ws_valid, 0);
        check("r32_fwd", ms_to_ds_fwd_bus, 0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #2;
        check("r32_valid_after", ms_to_ws_valid, 0);
        check("r32_allowin_after", ms_allowin, 1);

        // Randomized stream
        for (int n = 0; n < 400; n++) begin
            lt  = 3'($urandom_range(0, 7));
            alu = $urandom();
            if (lt == 3'd3 || lt == 3'd4) alu[0] = 1'b0;
            if (lt == 3'd5) alu[1:0] = 2'b00;
            rt  = $urandom();
            rd  = $urandom();
            d   = $urandom_range(0, 4);
            bus = mk_bus(lt, rt, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), alu, $urandom());
            tk  = 1'b0;
            for (int t = 0; t < 60 && !tk; t++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 3) != 0);
                else run_cycle(1'b1, bus, d, rd, $urandom_range(0, 3) != 0, tk);
            end
            check("issue_timeout", tk, 1);
        end
        for (int i = 0; i < 8; i++) idle_cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
